// File: rtl/tank_level_emulator.sv
// ----------------------------------------------------------------------------
// tank_level_emulator
//
// Cycle-based model of a water tank with three level sensors. It closes the
// loop around an irrigation controller. The controller's valve commands are
// integrated into a tank level once per simulation tick. Registered
// high/middle/low sensor lines are derived from that level. A fault input
// forces inconsistent sensor patterns or freezes the level, so the
// controller's error and alarm paths can be exercised.
//
// Ports:
//   clock               system clock
//   reset               synchronous, active-high reset (priority over all)
//   enable              1 = prescaler runs; 0 = prescaler and level frozen
//   valvulaEntrada      inlet valve command (adds FILL_RATE per tick)
//   valvulaAspersao     sprinkler valve command (removes SPRINK_RATE per tick)
//   valvulaGotejamento  drip valve command (removes DRIP_RATE per tick)
//   fault[1:0]          00 normal, 01 high stuck 1, 10 low stuck 0,
//                       11 level frozen
//   high/middle/low     registered sensor outputs (1 = submerged)
//   nivel               current tank level
//   tick                one-cycle pulse per simulation tick
//   overflow            sticky: a tick tried to fill beyond CAPACITY
//   dry                 registered (nivel == 0)
// ----------------------------------------------------------------------------
module tank_level_emulator #(
    parameter int LEVEL_W     = 8,
    parameter int CAPACITY    = 200,
    parameter int LOW_TH      = 50,
    parameter int MID_TH      = 100,
    parameter int HIGH_TH     = 150,
    parameter int FILL_RATE   = 4,
    parameter int SPRINK_RATE = 3,
    parameter int DRIP_RATE   = 1,
    parameter int TICK_DIV    = 1000,
    parameter int INIT_LEVEL  = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               valvulaEntrada,
    input  logic               valvulaAspersao,
    input  logic               valvulaGotejamento,
    input  logic [1:0]         fault,
    output logic               high,
    output logic               middle,
    output logic               low,
    output logic [LEVEL_W-1:0] nivel,
    output logic               tick,
    output logic               overflow,
    output logic               dry
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Two extra bits give a sign bit plus headroom for nivel + FILL_RATE.
    localparam int SUM_W = LEVEL_W + 2;

    localparam logic [CNT_W-1:0]          CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0]        INIT_L  = LEVEL_W'(INIT_LEVEL);
    localparam logic [LEVEL_W-1:0]        LOW_T   = LEVEL_W'(LOW_TH);
    localparam logic [LEVEL_W-1:0]        MID_T   = LEVEL_W'(MID_TH);
    localparam logic [LEVEL_W-1:0]        HIGH_T  = LEVEL_W'(HIGH_TH);
    localparam logic signed [SUM_W-1:0]   CAP_S   = SUM_W'(CAPACITY);
    localparam logic signed [SUM_W-1:0]   FILL_S  = SUM_W'(FILL_RATE);
    localparam logic signed [SUM_W-1:0]   SPRK_S  = SUM_W'(SPRINK_RATE);
    localparam logic signed [SUM_W-1:0]   DRIP_S  = SUM_W'(DRIP_RATE);

    // Clamp a signed candidate level into [0, CAPACITY].
    function automatic logic [LEVEL_W-1:0] sat_level(input logic signed [SUM_W-1:0] s);
        if (s < 0)
            return '0;
        else if (s > CAP_S)
            return CAP_S[LEVEL_W-1:0];
        else
            return s[LEVEL_W-1:0];
    endfunction

    function automatic logic is_over(input logic signed [SUM_W-1:0] s);
        return (s > CAP_S);
    endfunction

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [LEVEL_W-1:0] nivel_q, nivel_d;
    logic               ovf_q, ovf_d;
    logic               high_q, high_d;
    logic               mid_q, mid_d;
    logic               low_q, low_d;
    logic               dry_q, dry_d;

    logic                     wrap;
    logic signed [SUM_W-1:0]  sum;

    always_comb begin
        cnt_d   = cnt_q;
        nivel_d = nivel_q;
        ovf_d   = ovf_q;
        wrap    = enable && (cnt_q == CNT_MAX);

        // Net delta of all open valves; all-open applies the combined delta.
        sum = $signed({2'b00, nivel_q})
            + (valvulaEntrada     ? FILL_S : '0)
            - (valvulaAspersao    ? SPRK_S : '0)
            - (valvulaGotejamento ? DRIP_S : '0);

        if (enable)
            cnt_d = wrap ? '0 : cnt_q + 1'b1;

        // tick is registered, so it appears on the cycle after CNT_MAX.
        tick_d = wrap;

        // Valves only matter on the wrap edge; fault 11 freezes the level
        // and leaves overflow untouched while the prescaler keeps running.
        if (wrap && (fault != 2'b11)) begin
            nivel_d = sat_level(sum);
            if (is_over(sum))
                ovf_d = 1'b1;
        end

        // Sensors track the current level; fault overrides follow the compare.
        high_d = (nivel_q >= HIGH_T) || (fault == 2'b01);
        mid_d  = (nivel_q >= MID_T);
        low_d  = (nivel_q >= LOW_T) && (fault != 2'b10);
        dry_d  = (nivel_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            nivel_q <= INIT_L;
            ovf_q   <= 1'b0;
            high_q  <= 1'b0;
            mid_q   <= 1'b0;
            low_q   <= 1'b0;
            dry_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            nivel_q <= nivel_d;
            ovf_q   <= ovf_d;
            high_q  <= high_d;
            mid_q   <= mid_d;
            low_q   <= low_d;
            dry_q   <= dry_d;
        end
    end

    assign high     = high_q;
    assign middle   = mid_q;
    assign low      = low_q;
    assign nivel    = nivel_q;
    assign tick     = tick_q;
    assign overflow = ovf_q;
    assign dry      = dry_q;

endmodule

// File: doc/tank_level_emulator.md
Name: tank_level_emulator

Overview:
- Cycle-based model of the water tank and its three level sensors. It drives the high/middle/low sensor lines that the irrigation controller consumes.
- It consumes the controller's inlet, sprinkler and drip valve commands and integrates the tank level over time.
- Closes the loop for on-board demos and self-checking benches, with fault injection to exercise the controller's sensor-error and alarm paths.

Parameters:
- LEVEL_W, 8, width of level register
- CAPACITY, 200, maximum level (saturation ceiling)
- LOW_TH, 50, level at or above which low sensor is submerged
- MID_TH, 100, level at or above which middle sensor is submerged
- HIGH_TH, 150, level at or above which high sensor is submerged
- FILL_RATE, 4, units added per tick with inlet valve open
- SPRINK_RATE, 3, units removed per tick with sprinkler valve open
- DRIP_RATE, 1, units removed per tick with drip valve open
- TICK_DIV, 1000, clock cycles per simulation tick (>=2)
- INIT_LEVEL, 0, level loaded on reset (<= CAPACITY)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = prescaler runs; 0 = prescaler and level frozen
- valvulaEntrada  in  1  inlet valve command (1 = open)
- valvulaAspersao  in  1  sprinkler valve command
- valvulaGotejamento  in  1  drip valve command
- fault  in  2  00 normal, 01 high stuck at 1, 10 low stuck at 0, 11 level frozen
- high  out  1  high sensor (1 = submerged)
- middle  out  1  middle sensor
- low  out  1  low sensor
- nivel  out  LEVEL_W  current level
- tick  out  1  one-cycle pulse per simulation tick
- overflow  out  1  sticky: fill attempted beyond CAPACITY
- dry  out  1  level == 0

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: prescaler=0, tick=0, nivel=INIT_LEVEL, high=middle=low=0, overflow=0, dry=0.
- Reset mid-operation aborts the current tick and has priority over all other inputs.
- Prescaler:
  - When enable=1, counts 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the cycle after the counter reaches TICK_DIV-1, so the first tick comes TICK_DIV cycles after reset release.
  - When enable=0, the counter holds, tick=0, and nivel holds.
- Level update, on the clock edge where the prescaler wraps (same edge that sets tick):
  - sum = nivel + FILL_RATE*valvulaEntrada - SPRINK_RATE*valvulaAspersao - DRIP_RATE*valvulaGotejamento.
  - Evaluate in signed LEVEL_W+2 bits.
  - sum < 0 -> nivel=0.
  - sum > CAPACITY -> nivel=CAPACITY and overflow set (sticky until reset).
  - Otherwise nivel=sum.
  - Valve inputs are sampled only on that edge; glitches between ticks have no effect.
  - All valves open simultaneously: the net delta is applied (default +4-3-1 = 0, level unchanged).
- fault=11: nivel holds on ticks and overflow is not updated; the prescaler and tick keep running.
- dry: registered, equals (nivel==0) with one cycle latency, same as the sensors.
- Sensors: registered every cycle from current nivel, one cycle latency.
  - low = nivel>=LOW_TH.
  - middle = nivel>=MID_TH.
  - high = nivel>=HIGH_TH.
  - Thresholds are inclusive; physically consistent patterns only (high implies middle implies low) when fault=00.
- Fault overrides are applied after the threshold compare and take effect with the same one-cycle latency:
  - 01 forces high=1.
  - 10 forces low=0.
  - This yields inconsistent patterns, e.g. high=1, middle=0, low=0, for the controller's error detector.
- Changing fault mid-run takes effect on the next clock; it never alters nivel except as described for 11.

Test Plan (TICK_DIV=4, other parameters default):
- Reset, then valvulaEntrada=1 for 13 ticks -> tick pulses every 4 cycles; nivel 4,8,...,52; low rises one cycle after nivel reaches 52; middle/high stay 0.
- INIT_LEVEL=198, valvulaEntrada=1 -> after 1 tick nivel=200, overflow=1, high=middle=low=1; further ticks keep nivel=200; overflow stays 1 after valve closes.
- nivel=2, valvulaAspersao=1 -> next tick nivel=0 (saturated, not wrapped to 255), dry=1 one cycle later; valvulaEntrada=1 with aspersao and gotejamento=1 -> nivel stays 0.
- nivel=100, fault=01 -> next cycle high=1, middle=1, low=1; nivel=40 with fault=01 -> high=1, middle=0, low=0; fault=10 at nivel=160 -> low=0, middle=1, high=1.
- nivel=120, fault=11, valvulaEntrada=1 for 5 ticks -> nivel stays 120, tick still pulses; enable=0 for 20 cycles -> no tick and counter frozen, resumes where it stopped.
- Assert reset on the cycle before a tick with valvulaEntrada=1 -> nivel=INIT_LEVEL, overflow=0, no tick; the first tick comes 4 cycles after reset deasserts.
